fetch_pc: RTL
=============

# fetch_pc

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter and the IF/ID pipeline register, and drives the instruction-memory address. It consumes the decode stage's results (branch decision, sign-extended immediate, jump/jr targets) to pick the next PC. It honours hazard stalls, exception entry and `eret` return, and it flags fetch-address exceptions and delay-slot membership for the instruction it hands to decode.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC loaded on reset
- `HANDLER_PC`, 32'h0000_4180, exception entry vector
- `IM_LO`, 32'h0000_3000, lowest legal fetch address
- `IM_HI`, 32'h0000_6FFC, highest legal fetch address

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `im_rdata`  in  32  instruction word at `if_pc` (combinational IM)
- `br_taken`  in  1  ID branch resolved taken (comparator result already qualified by branch type)
- `br_imm`  in  32  ID sign-extended 16-bit immediate
- `is_j`  in  1  ID holds `j`/`jal`
- `is_jr`  in  1  ID holds `jr`/`jalr`
- `jr_target`  in  32  forwarded rs value
- `id_is_ctrl`  in  1  ID holds any branch/jump, taken or not
- `exc_req`  in  1  exception/interrupt accepted this cycle
- `eret_req`  in  1  `eret` committing this cycle
- `epc`  in  32  return address for `eret`
- `if_pc`  out  32  fetch address to IM
- `id_instr`  out  32  IF/ID instruction
- `id_pc`  out  32  IF/ID PC
- `id_bd`  out  1  IF/ID instruction is a delay slot
- `id_excode`  out  5  IF/ID exception code (0 none, 4 AdEL)

## Operation
- Next-PC priority, high to low: `exc_req` -> `HANDLER_PC`; `eret_req` -> `epc`; `stall` -> hold; `is_jr` -> `jr_target`; `is_j` -> {`id_pc[31:28]`, `id_instr[25:0]`, 2'b00}; `br_taken` -> `id_pc` + 4 + (`br_imm` << 2); otherwise `if_pc` + 4.
- All adds are 32-bit modulo 2^32. Wrap is not trapped. The AdEL check catches it.
- IF/ID update:
  - `exc_req` or `eret_req`: flush. Writes `id_instr`=0, `id_pc`=0, `id_bd`=0, `id_excode`=0. No delay slot survives either event.
  - `stall` alone: hold all IF/ID fields.
  - Otherwise, load `id_pc`=`if_pc` and `id_bd`=`id_is_ctrl`.
  - On that load, if `if_pc[1:0]`!=0 or `if_pc` is outside [`IM_LO`,`IM_HI`], write `id_excode`=4 and `id_instr`=0, leaving a nop with the exception tag. Otherwise write `id_excode`=0 and `id_instr`=`im_rdata`.
- The delay slot always executes. A taken branch never squashes the fetched instruction.
- `exc_req` and `eret_req` both high: `exc_req` wins.

## Timing
- Reset (async assert, sync deassert by the system) sets `if_pc`=`RESET_PC` and `id_instr`=0, `id_pc`=0, `id_bd`=0, `id_excode`=0.
- Fetch-to-decode latency is 1 cycle. The instruction at `if_pc` in cycle n appears on `id_instr` in cycle n+1.
- Redirect takes effect on the next edge. The instruction fetched in the branch's ID cycle is the delay slot, and the target is fetched in the following cycle.
- A stall of k cycles holds `if_pc` and IF/ID for exactly k edges. The first non-stall edge resumes with the normal priority.
- `exc_req` during `stall` still redirects and flushes on that edge.
- `reset` asserted mid-operation overrides everything immediately, without waiting for a clock edge.

## Structure
- Shared package constants: `RESET_PC`, `HANDLER_PC`, `IM_LO`, `IM_HI`, `EXC_NONE`=5'd0, `EXC_ADEL`=5'd4.
- One combinational sub-module, `npc_gen`, computes next-PC from the priority list. `fetch_pc` keeps the PC and IF/ID registers and the AdEL check.

## Test plan
- Reset, then 3 unstalled cycles -> `if_pc` steps 3000, 3004, 3008, 300C. `id_pc` lags by one cycle. `id_bd`=0.
- `beq` at `id_pc`=3010 with `br_taken`=1 and `br_imm`=FFFF_FFFE -> next `if_pc`=300C. The delay slot from 3014 enters ID with `id_bd`=1.
- `j` with `id_instr[25:0]`=0x000C00, `id_pc`=3020 -> `if_pc`=0000_3000 after one edge.
- `stall` high for 2 cycles at `if_pc`=3040 -> `if_pc` and IF/ID are unchanged for 2 edges, then `if_pc`=3044.
- `jr` with `jr_target`=3002 -> next fetch gives `id_excode`=4, `id_instr`=0, `id_pc`=3002. Repeat with `jr_target`=7000 -> `id_excode`=4.
- `exc_req` and `stall` both high -> `if_pc`=4180 and IF/ID flushed. Later `eret_req` with `epc`=3058 -> `if_pc`=3058 and IF/ID flushed.

Source files
------------

// File: rtl/fetch_pc_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Address map, exception codes and the next-PC source encoding live here.
package fetch_pc_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    // Which rule won the next-PC priority.
    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_BR,
        NPC_J,
        NPC_JR,
        NPC_HOLD,
        NPC_ERET,
        NPC_EXC
    } npc_sel_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  excode;
    } ifid_t;

    localparam ifid_t IFID_FLUSH = '{instr: 32'd0, pc: 32'd0, bd: 1'b0, excode: EXC_NONE};

    // Fetch address error: misaligned or outside the instruction memory window.
    function automatic logic fetch_adel(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/fetch_pc_npc_gen.sv
// Combinational next-PC selection for the fetch stage.
// Reports which rule was chosen so the caller can steer the IF/ID register.
module npc_gen
    import fetch_pc_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC_P = HANDLER_PC
) (
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic        stall,
    input  logic        is_jr,
    input  logic        is_j,
    input  logic        br_taken,
    input  logic [31:0] if_pc,
    input  logic [31:0] id_pc,
    input  logic [25:0] j_index,
    input  logic [31:0] br_imm,
    input  logic [31:0] jr_target,
    input  logic [31:0] epc,
    output logic [31:0] npc,
    output npc_sel_e    sel
);

    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic [31:0] br_pc;
    logic [31:0] j_pc;

    assign seq_pc = if_pc + 32'd4;
    assign br_off = br_imm << 2;
    // Branch target is relative to the delay slot, i.e. the branch's own PC + 4.
    assign br_pc  = id_pc + 32'd4 + br_off;
    assign j_pc   = {id_pc[31:28], j_index, 2'b00};

    always_comb begin
        npc = seq_pc;
        sel = NPC_SEQ;
        if (exc_req) begin
            npc = HANDLER_PC_P;
            sel = NPC_EXC;
        end else if (eret_req) begin
            npc = epc;
            sel = NPC_ERET;
        end else if (stall) begin
            npc = if_pc;
            sel = NPC_HOLD;
        end else if (is_jr) begin
            npc = jr_target;
            sel = NPC_JR;
        end else if (is_j) begin
            npc = j_pc;
            sel = NPC_J;
        end else if (br_taken) begin
            npc = br_pc;
            sel = NPC_BR;
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register and
// fetch-address (AdEL) tagging of the instruction handed to decode.
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P   = RESET_PC,
    parameter logic [31:0] HANDLER_PC_P = HANDLER_PC,
    parameter logic [31:0] IM_LO_P      = IM_LO,
    parameter logic [31:0] IM_HI_P      = IM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] im_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_imm,
    input  logic        is_j,
    input  logic        is_jr,
    input  logic [31:0] jr_target,
    input  logic        id_is_ctrl,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] if_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_bd,
    output logic [4:0]  id_excode
);

    logic [31:0] pc_q;
    logic [31:0] npc;
    npc_sel_e    sel;
    ifid_t       ifid_q;
    ifid_t       ifid_d;
    logic        adel;

    npc_gen #(
        .HANDLER_PC_P (HANDLER_PC_P)
    ) u_npc_gen (
        .exc_req   (exc_req),
        .eret_req  (eret_req),
        .stall     (stall),
        .is_jr     (is_jr),
        .is_j      (is_j),
        .br_taken  (br_taken),
        .if_pc     (pc_q),
        .id_pc     (ifid_q.pc),
        .j_index   (ifid_q.instr[25:0]),
        .br_imm    (br_imm),
        .jr_target (jr_target),
        .epc       (epc),
        .npc       (npc),
        .sel       (sel)
    );

    assign adel = fetch_adel(pc_q, IM_LO_P, IM_HI_P);

    // A faulting fetch becomes a nop carrying the AdEL tag down the pipe.
    always_comb begin
        ifid_d = ifid_q;
        case (sel)
            NPC_EXC, NPC_ERET: ifid_d = IFID_FLUSH;
            NPC_HOLD:          ifid_d = ifid_q;
            default: begin
                ifid_d.pc     = pc_q;
                ifid_d.bd     = id_is_ctrl;
                ifid_d.excode = adel ? EXC_ADEL : EXC_NONE;
                ifid_d.instr  = adel ? 32'd0 : im_rdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC_P;
            ifid_q <= IFID_FLUSH;
        end else begin
            pc_q   <= npc;
            ifid_q <= ifid_d;
        end
    end

    assign if_pc     = pc_q;
    assign id_instr  = ifid_q.instr;
    assign id_pc     = ifid_q.pc;
    assign id_bd     = ifid_q.bd;
    assign id_excode = ifid_q.excode;

endmodule
